// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and defaults for the PLL reset controller and its helpers.
package pll_reset_ctrl_pkg;

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } pll_rst_state_t;

   localparam int DEF_SYNC_STAGES         = 2;
   localparam int DEF_PLL_RST_CYCLES      = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
   localparam int DEF_CNT_W               = 17;

   localparam int RELOCK_W = 8;

   // Increment that sticks at all-ones instead of wrapping back to zero.
   function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
      logic [RELOCK_W-1:0] r;
      r = (v == {RELOCK_W{1'b1}}) ? v : v + RELOCK_W'(1);
      return r;
   endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] chain_q;
   logic [SYNC_STAGES-1:0] chain_d;

   // Shift the raw input one stage further down the chain each cycle.
   always_comb begin
      chain_d = {chain_q[SYNC_STAGES-2:0], async_in};
   end

   // Chain flops, cleared on reset so the output reads as "not asserted".
   always_ff @(posedge clock) begin
      if (reset) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign sync_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock and
// only then releases the core reset; any loss of lock restarts the sequence.
module pll_reset_ctrl
   import pll_reset_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
   parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int CNT_W               = DEF_CNT_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                pll_locked,
   output logic                pll_rst,
   output logic                sys_reset,
   output logic                lock_lost,
   output logic [RELOCK_W-1:0] relock_count
);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

   pll_rst_state_t      state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                lock_lost_q, lock_lost_d;
   logic [RELOCK_W-1:0] relock_count_q, relock_count_d;
   logic                pll_rst_q, pll_rst_d;
   logic                sys_reset_q, sys_reset_d;
   logic                relock_inc;
   logic                locked_sync;

   sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clock   (clock),
      .reset   (reset),
      .async_in(pll_locked),
      .sync_out(locked_sync)
   );

   // State register plus the registered outputs derived from next-state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= PLL_RESET;
         cnt_q          <= '0;
         lock_lost_q    <= 1'b0;
         relock_count_q <= '0;
         pll_rst_q      <= 1'b1;
         sys_reset_q    <= 1'b1;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         lock_lost_q    <= lock_lost_d;
         relock_count_q <= relock_count_d;
         pll_rst_q      <= pll_rst_d;
         sys_reset_q    <= sys_reset_d;
      end
   end

   // Sequencing decisions; the shared counter restarts on every state change.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      lock_lost_d = lock_lost_q;
      relock_inc  = 1'b0;
      case (state_q)
         PLL_RESET: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         WAIT_LOCK: begin
            if (locked_sync) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d    = PLL_RESET;
               cnt_d      = '0;
               relock_inc = 1'b1;
            end
         end
         STABLE: begin
            if (!locked_sync) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cnt_d = '0;
            if (!locked_sync) begin
               state_d     = PLL_RESET;
               lock_lost_d = 1'b1;
               relock_inc  = 1'b1;
            end
         end
         default: begin
            state_d = PLL_RESET;
            cnt_d   = '0;
         end
      endcase
      relock_count_d = relock_inc ? sat_inc(relock_count_q) : relock_count_q;
   end

   // Output decode from next-state so the outputs change on the transition edge.
   always_comb begin
      pll_rst_d   = (state_d == PLL_RESET);
      sys_reset_d = (state_d != RUN);
   end

   assign pll_rst      = pll_rst_q;
   assign sys_reset    = sys_reset_q;
   assign lock_lost    = lock_lost_q;
   assign relock_count = relock_count_q;

endmodule

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
- Consumer end of the PLL's refclk/rst/locked interface. Drives the PLL reset input and watches its locked output.
- Releases the system reset only after lock has been continuously stable for a set time.
- On loss of lock, forces a PLL re-lock sequence.
- Runs on the 50 MHz reference clock and sits between the board clock input, the PLL and the core reset tree.

Parameters:
- SYNC_STAGES, 2, flop stages synchronising the asynchronous pll_locked input (min 2).
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per reset pulse (min 1).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before sys_reset releases (min 1).
- LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK without lock before a retry (min 1).
- CNT_W, 17, counter width; must hold max(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)-1.

Ports:
- clock  in  1  reference clock, same net as PLL refclk; the only clock.
- reset  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked output; asynchronous to clock; may glitch.
- pll_rst  out  1  PLL reset request, active-high.
- sys_reset  out  1  system reset to core, active-high, registered.
- lock_lost  out  1  sticky flag: lock dropped while in RUN; cleared only by reset.
- relock_count  out  8  number of PLL re-reset attempts; saturates at 255; cleared only by reset.

Behaviour:
- Reset is sampled on a clock edge. While reset=1:
  - state=PLL_RESET, cnt=0.
  - Synchroniser flops=0.
  - pll_rst=1, sys_reset=1, lock_lost=0, relock_count=0.
- locked_sync is the output of a SYNC_STAGES flop chain on pll_locked. All decisions use locked_sync only.
- Single counter cnt (CNT_W bits), cleared on every state change.
- PLL_RESET:
  - pll_rst=1.
  - cnt increments each cycle; at cnt==PLL_RST_CYCLES-1 → WAIT_LOCK.
  - locked_sync is ignored in this state.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_sync=1 → STABLE.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1 → PLL_RESET and relock_count++ (saturating).
  - Else cnt++.
- STABLE:
  - If locked_sync=0 → WAIT_LOCK; this is a glitch, not a retry, so relock_count is unchanged.
  - Else if cnt==LOCK_STABLE_CYCLES-1 → RUN.
  - Else cnt++.
- RUN:
  - If locked_sync=0 → PLL_RESET, lock_lost<=1, relock_count++ (saturating).
- State encoding and outputs:
  - pll_rst and sys_reset are registered from next-state: pll_rst = (next==PLL_RESET), sys_reset = (next!=RUN). No combinational paths to outputs.
  - sys_reset is 1 in every state except RUN. It reasserts on the same edge the FSM leaves RUN.
- Latency:
  - pll_locked is first sampled high at edge e and stays high.
  - With state in WAIT_LOCK, sys_reset falls at edge e+SYNC_STAGES+LOCK_STABLE_CYCLES.
  - Example: first sampling edge = 1, SYNC=2, STABLE=4 → falls at edge 7.
  - Loss of lock in RUN: sys_reset rises SYNC_STAGES edges after pll_locked is first sampled low.
- Lock arriving during PLL_RESET:
  - No effect until the state reaches WAIT_LOCK.
  - If locked_sync is already 1 on the first WAIT_LOCK cycle → STABLE next edge.
- relock_count at 255 stays 255; lock_lost is unaffected by saturation.
- Reset asserted mid-sequence (any state) restarts at PLL_RESET on the next edge with full reset values.

Decomposition:
- Shared package holds:
  - state enum pll_rst_state_t {PLL_RESET, WAIT_LOCK, STABLE, RUN}.
  - Default parameter constants.
  - Relock counter width constant (8).
- One sub-module: sync_bit (parameterised SYNC_STAGES flop chain, synchronous reset to 0), reusable for other async inputs.
- Everything else, including the FSM and counters, lives in pll_reset_ctrl.

Test Plan:
All scenarios use SYNC=2, RST=3, STABLE=4, TIMEOUT=8 unless stated.
1. Power-up:
   - Stimulus: reset high 2 cycles, then low; pll_locked=0.
   - Required: pll_rst=1 for 3 cycles, then 0; after 8 WAIT_LOCK cycles, pll_rst=1 again and relock_count=1.
2. Normal lock:
   - Stimulus: raise pll_locked 2 cycles after pll_rst falls; first sampled high at edge 1.
   - Required: sys_reset falls at edge 7; lock_lost=0; relock_count=0.
3. Glitch during STABLE:
   - Stimulus: pll_locked pulses low for 1 cycle on the second STABLE cycle.
   - Required: return to WAIT_LOCK; relock_count unchanged; sys_reset stays 1; full 4-cycle STABLE window needed after recovery.
4. Loss in RUN:
   - Stimulus: in RUN, drop pll_locked.
   - Required: sys_reset=1 and pll_rst=1 two edges later; lock_lost=1; relock_count+1; re-lock then releases sys_reset with lock_lost still 1.
5. Saturation:
   - Stimulus: keep pll_locked=0 for 300 timeouts.
   - Required: relock_count holds 255; pll_rst keeps cycling.
6. Mid-operation reset:
   - Stimulus: assert reset in RUN with lock_lost=1.
   - Required: next edge gives pll_rst=1, sys_reset=1, lock_lost=0, relock_count=0.
